// File: rtl/fma_chk_pkg.sv
// Shared types and float helpers for the fpfma result checker.
// Single-precision field layout; used by fma_result_checker.
package fma_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chkState_t;

  localparam int FP_W = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;

  function automatic logic is_nan(
    input logic [FP_W-1:0] v
  );
    return (v[FP_W-2 -: EXP_W] == EXP_ALL_ONES)
        && (v[MAN_W-1:0] != '0);
  endfunction

  function automatic logic is_inf(
    input logic [FP_W-1:0] v
  );
    return (v[FP_W-2 -: EXP_W] == EXP_ALL_ONES)
        && (v[MAN_W-1:0] == '0);
  endfunction

endpackage

// File: rtl/fma_chk_fifo.sv
// Expected-value queue: synchronous FIFO with flush.
// Entries become visible at the head one cycle after the push.
module fma_chk_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wPtr;
  logic [AW:0]      rPtr;
  logic             doPush;
  logic             doPop;

  assign full = (wPtr[AW] != rPtr[AW])
             && (wPtr[AW-1:0] == rPtr[AW-1:0]);
  assign empty = (wPtr == rPtr);
  assign head = mem[rPtr[AW-1:0]];
  assign doPush = push && !full && !flush;
  assign doPop = pop && !empty && !flush;

  // Pointer bookkeeping; flush empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wPtr <= '0;
      rPtr <= '0;
    end else if (flush) begin
      wPtr <= '0;
      rPtr <= '0;
    end else begin
      if (doPush) wPtr <= wPtr + 1'b1;
      if (doPop) rPtr <= rPtr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (doPush) mem[wPtr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fma_result_checker.sv
// Compares fpfma results in order against queued expected values.
// Optional FMA_CHK_ULP_TOL_EN accepts +/-1 ULP on finite values.
module fma_result_checker
  import fma_chk_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int NUM_VEC = 100,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             exp_valid,
  input  logic [WIDTH-1:0] exp_data,
  output logic             exp_ready,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_data,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             fail_seen,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_got,
  output logic [WIDTH-1:0] first_fail_exp,
  output logic             underflow,
  output logic             busy,
  output logic             done
);

  chkState_t state;
  chkState_t stateNxt;

  logic             full;
  logic             empty;
  logic [WIDTH-1:0] hd;
  logic             pushReq;
  logic             popReq;
  logic             uflReq;
  logic             match;
  logic             tolOk;
  logic [CNT_W-1:0] passNxt;
  logic [CNT_W-1:0] failNxt;
  logic [CNT_W:0]   totNxt;
  logic [CNT_W:0]   totCur;

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign exp_ready = busy && !full;
  assign pushReq = exp_valid && exp_ready && !start;
  assign popReq = res_valid && busy && !empty && !start;
  assign uflReq = res_valid && busy && empty && !start;

  fma_chk_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) uFifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (pushReq),
    .pop  (popReq),
    .flush(start),
    .din  (exp_data),
    .full (full),
    .empty(empty),
    .head (hd)
  );

`ifdef FMA_CHK_ULP_TOL_EN
  logic [WIDTH-2:0] magA;
  logic [WIDTH-2:0] magB;
  logic [WIDTH-2:0] magD;

  // Magnitude distance; adjacent encodings differ by one ULP.
  always_comb begin
    magA = hd[WIDTH-2:0];
    magB = res_data[WIDTH-2:0];
    magD = (magA >= magB) ? magA - magB : magB - magA;
    tolOk = (hd[WIDTH-1] == res_data[WIDTH-1])
         && !is_nan(hd) && !is_nan(res_data)
         && !is_inf(hd) && !is_inf(res_data)
         && (magD <= 1);
  end
`else
  assign tolOk = 1'b0;
`endif

  assign match = (hd == res_data)
              || (is_nan(hd) && is_nan(res_data))
              || tolOk;

  // Saturating next-count values for the current pop.
  always_comb begin
    passNxt = pass_cnt;
    failNxt = fail_cnt;
    if (popReq) begin
      if (match) begin
        if (pass_cnt != '1) passNxt = pass_cnt + 1'b1;
      end else begin
        if (fail_cnt != '1) failNxt = fail_cnt + 1'b1;
      end
    end
    totNxt = {1'b0, passNxt} + {1'b0, failNxt};
    totCur = {1'b0, pass_cnt} + {1'b0, fail_cnt};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= stateNxt;
  end

  // Next state: start always (re)enters RUN; run ends on the last vector.
  always_comb begin
    stateNxt = state;
    if (start) begin
      stateNxt = RUN;
    end else if (popReq
        && totNxt == (CNT_W+1)'(NUM_VEC)) begin
      stateNxt = DONE;
    end
  end

  // Tallies, first-failure capture and underflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      fail_seen      <= 1'b0;
      first_fail_idx <= '0;
      first_fail_got <= '0;
      first_fail_exp <= '0;
      underflow      <= 1'b0;
    end else if (start) begin
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      fail_seen      <= 1'b0;
      first_fail_idx <= '0;
      first_fail_got <= '0;
      first_fail_exp <= '0;
      underflow      <= 1'b0;
    end else begin
      pass_cnt <= passNxt;
      fail_cnt <= failNxt;
      if (uflReq) underflow <= 1'b1;
      if (popReq && !match && !fail_seen) begin
        fail_seen      <= 1'b1;
        first_fail_idx <= totCur[CNT_W-1:0];
        first_fail_got <= res_data;
        first_fail_exp <= hd;
      end
    end
  end

endmodule

// File: tb/tb_fma_result_checker.sv
// Directed self-checking bench for fma_result_checker.
// Run with NUM_VEC=4, DEPTH=8; expectations follow FMA_CHK_ULP_TOL_EN.
module tb_fma_result_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_data = '0;
  logic        exp_ready;
  logic        res_valid = 1'b0;
  logic [31:0] res_data = '0;
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;
  logic        fail_seen;
  logic [15:0] first_fail_idx;
  logic [31:0] first_fail_got;
  logic [31:0] first_fail_exp;
  logic        underflow;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fma_result_checker #(
    .WIDTH(32),
    .DEPTH(8),
    .NUM_VEC(4),
    .CNT_W(16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .exp_valid     (exp_valid),
    .exp_data      (exp_data),
    .exp_ready     (exp_ready),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .pass_cnt      (pass_cnt),
    .fail_cnt      (fail_cnt),
    .fail_seen     (fail_seen),
    .first_fail_idx(first_fail_idx),
    .first_fail_got(first_fail_got),
    .first_fail_exp(first_fail_exp),
    .underflow     (underflow),
    .busy          (busy),
    .done          (done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [31:0] v);
    exp_valid = 1'b1;
    exp_data = v;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic ret(input logic [31:0] v);
    res_valid = 1'b1;
    res_data = v;
    tick();
    res_valid = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_pass", 32'(pass_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(exp_ready), 0);
    rst_n = 1'b1;
    tick();

    // Two matching vectors, then complete the 4-vector run.
    doStart();
    chk("start_busy", 32'(busy), 1);
    push(32'h3F800000);
    push(32'h40A00000);
    ret(32'h3F800000);
    ret(32'h40A00000);
    chk("two_pass", 32'(pass_cnt), 2);
    chk("two_fail", 32'(fail_cnt), 0);
    chk("two_seen", 32'(fail_seen), 0);
    push(32'h40000000);
    push(32'h40400000);
    ret(32'h40000000);
    chk("pre_done", 32'(done), 0);
    ret(32'h40400000);
    chk("done", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
    ret(32'h40400000);
    chk("ignored", 32'(pass_cnt), 4);

    // First-failure capture and ULP tolerance.
    doStart();
    chk("restart_pass", 32'(pass_cnt), 0);
    push(32'h3F800000);
    push(32'h3F800000);
    push(32'h40400000);
    push(32'h40800000);
    ret(32'h3F800000);
    ret(32'h3F800000);
    ret(32'h40400001);
    ret(32'h40800005);
`ifdef FMA_CHK_ULP_TOL_EN
    chk("ff_fail", 32'(fail_cnt), 1);
    chk("ff_idx", 32'(first_fail_idx), 3);
    chk("ff_got", first_fail_got, 32'h40800005);
    chk("ff_exp", first_fail_exp, 32'h40800000);
`else
    chk("ff_fail", 32'(fail_cnt), 2);
    chk("ff_idx", 32'(first_fail_idx), 2);
    chk("ff_got", first_fail_got, 32'h40400001);
    chk("ff_exp", first_fail_exp, 32'h40400000);
`endif
    chk("ff_seen", 32'(fail_seen), 1);

    // NaN equivalence; infinity never tolerated.
    doStart();
    push(32'h7FC00000);
    push(32'h7F800000);
    ret(32'hFFC00001);
    chk("nan_pass", 32'(pass_cnt), 1);
    ret(32'h7F7FFFFF);
    chk("inf_fail", 32'(fail_cnt), 1);

    // Underflow with a same-cycle push: no bypass.
    exp_valid = 1'b1;
    exp_data = 32'h40000000;
    res_valid = 1'b1;
    res_data = 32'h40000000;
    tick();
    exp_valid = 1'b0;
    res_valid = 1'b0;
    chk("ufl_flag", 32'(underflow), 1);
    chk("ufl_pass", 32'(pass_cnt), 1);
    chk("ufl_fail", 32'(fail_cnt), 1);
    ret(32'h40000000);
    chk("ufl_kept", 32'(pass_cnt), 2);

    // Fill the queue, then restart mid-run.
    doStart();
    for (int i = 0; i < 8; i++) push(32'(i));
    chk("full_ready", 32'(exp_ready), 0);
    ret(32'h00000000);
    chk("full_pop", 32'(pass_cnt), 1);
    doStart();
    chk("rs_pass", 32'(pass_cnt), 0);
    chk("rs_ready", 32'(exp_ready), 1);
    ret(32'h00000001);
    chk("rs_empty", 32'(underflow), 1);
    chk("rs_cnt", 32'(pass_cnt), 0);

    // Asynchronous reset mid-run.
    push(32'h3F800000);
    ret(32'h00000000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_fail", 32'(fail_cnt), 0);
    chk("ar_seen", 32'(fail_seen), 0);
    chk("ar_ufl", 32'(underflow), 0);
    chk("ar_ready", 32'(exp_ready), 0);
    chk("ar_done", 32'(done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fma_result_checker.md
# fma_result_checker

Hardware result checker for the `fpfma` datapath; it is the receiving end of the vector stream that the stimulus side drives. Expected results are pushed into an internal queue alongside each operand triple. The results returned by `fpfma` are popped in order, compared, and tallied. Pass/fail counts and first-failure capture are exposed for on-chip self-test and for the simulation bench.

## Interface
- `WIDTH`, 32: operand/result width (IEEE-754 single).
- `DEPTH`, 8: expected-value queue depth, power of two, ≥2.
- `NUM_VEC`, 100: vectors per run; run ends when pass+fail reaches it.
- `CNT_W`, 16: counter/index width.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse; begins a run and clears all counters and captures.
- `exp_valid`  in  1  expected-value push request.
- `exp_data`  in  WIDTH  expected result.
- `exp_ready`  out  1  queue accepts a push this cycle.
- `res_valid`  in  1  `fpfma` result valid; no backpressure.
- `res_data`  in  WIDTH  `fpfma` result.
- `pass_cnt`  out  CNT_W  matching results.
- `fail_cnt`  out  CNT_W  mismatching results.
- `fail_seen`  out  1  sticky; at least one mismatch this run.
- `first_fail_idx`  out  CNT_W  vector index (0-based) of first mismatch.
- `first_fail_got`  out  WIDTH  result at first mismatch.
- `first_fail_exp`  out  WIDTH  expected value at first mismatch.
- `underflow`  out  1  sticky; result arrived with queue empty.
- `busy`  out  1  state is RUN.
- `done`  out  1  state is DONE.

## Operation
- FSM IDLE → RUN on `start`. RUN → DONE when the post-update pass+fail equals `NUM_VEC`. DONE → RUN on `start`. `start` in RUN restarts: counters cleared, queue flushed, state stays RUN.
- Push: `exp_valid && exp_ready`. `exp_ready = busy && !full`, using registered `full`. A pop in the same cycle does not free a slot for that cycle's push.
- Pop: `res_valid && busy && !empty`. The head is compared against `res_data`.
- `res_valid` with the queue empty in RUN: result dropped and `underflow` set. This applies even if a push happens the same cycle; there is no bypass.
- `res_valid` outside RUN: ignored.
- Match rule:
  - Bitwise equal → pass.
  - Both values NaN (exponent all ones, mantissa ≠0), any payload or sign → pass.
  - Otherwise → fail.
- On fail with `fail_seen`=0: capture index (= pass+fail before the update), got, and exp; set `fail_seen`.
- Counters saturate at all-ones.
- Reset: state IDLE, queue empty, all outputs 0.

## Timing
- Push-to-visible: an entry pushed in cycle N can be popped in cycle N+1.
- Compare latency 1: counters, captures, and `underflow` update on the edge after the pop/result cycle.
- `done` asserts in the same cycle the final counter value becomes visible.
- `start` takes effect at the next edge; it has priority over a simultaneous pop or push, both of which are discarded.
- Async reset mid-run clears everything immediately; the run is not resumed.

## Configuration
- `FMA_CHK_ULP_TOL_EN`:
  - Defined: a non-NaN mismatch also passes when signs are equal and the unsigned difference of bits [WIDTH-2:0] is ≤1. This tolerates ±1 ULP rounding differences, including across the exponent boundary.
  - Undefined: exact-match rule only.
- The tolerance is never applied when either value is NaN or infinity.

## Structure
- Shared package `fma_chk_pkg`:
  - FSM state enum (IDLE, RUN, DONE).
  - Float field constants: exponent/mantissa widths, `EXP_ALL_ONES`.
  - `is_nan` function.
- One sub-module `fma_chk_fifo`: synchronous FIFO, parameters WIDTH/DEPTH, ports push/pop/flush/full/empty/head.
- Comparison and FSM live in the top.

## Test plan
- Reset, then `start`, push 3F800000 and 40A00000, return the same two results → pass_cnt=2, fail_cnt=0, `fail_seen`=0.
- `NUM_VEC`=4, four matching vectors → `done`=1 one cycle after the 4th result, `busy`=0; later results ignored.
- Expected 40400000, got 40400001, 3rd vector → fail_cnt=1, first_fail_idx=2, got/exp captured. A later fail leaves the capture unchanged. With `FMA_CHK_ULP_TOL_EN` defined → pass.
- Expected 7FC00000, got FFC00001 → pass. Expected 7F800000, got 7F7FFFFF → fail, even with the macro defined.
- `res_valid` with an empty queue while pushing in the same cycle → `underflow`=1, counters unchanged, the pushed entry remains for the next result.
- Push 8 entries with DEPTH=8 → `exp_ready`=0. `start` mid-run → counters 0, queue empty. `rst_n` low mid-run → all outputs 0, state IDLE.
